// File: rtl/if_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Covers the fetch entry layout, instruction constants and B-type immediate decode.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef logic [31:0]     instr_t;
    typedef logic [XLEN-1:0] data_t;

    localparam instr_t     NOP           = 32'h0000_0013;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef struct packed {
        data_t  pc;
        data_t  pc_p4;
        instr_t instr;
        logic   pred;
    } fetch_entry_t;

    // Sign-extended B-type immediate; bit 0 is always zero.
    function automatic data_t imm_b(instr_t i);
        return {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // A branch with a negative offset jumps backward, so BTFN predicts it taken.
    function automatic logic is_bwd_branch(instr_t i);
        return (i[6:0] == OPCODE_BRANCH) && i[31];
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// The head is read straight from the storage array, so the output is registered.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: credit-limited sequential requests, response buffering,
// static BTFN prediction and redirect handling with stale-response dropping.
module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_p4_out,
    output logic [31:0]     instr_out,
    output logic            branch_take_out,
    output logic            flush_out
);
    import if_fetch_unit_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc, resp_pc, pred_target;
    logic [CW-1:0]   outstanding, outstanding_nxt, drop_cnt, fifo_count;
    logic [CW:0]     credit_used;
    logic            pred_redirect;
    logic            accept, push, pop, pred_hit;
    fetch_entry_t    push_entry, head;

    always_comb begin
        outstanding_nxt  = outstanding + CW'(imem_gnt) - CW'(imem_rvalid);
        credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
        accept           = imem_rvalid && (drop_cnt == '0);
        // A response arriving with a redirect belongs to the old path.
        push             = accept && !redirect_valid;
        pred_hit         = is_bwd_branch(imem_rdata);
        push_entry.pc    = resp_pc;
        push_entry.pc_p4 = resp_pc + XLEN'(4);
        push_entry.instr = imem_rdata;
        push_entry.pred  = pred_hit;
    end

    assign imem_req  = !rst && (credit_used < (CW+1)'(FIFO_DEPTH))
                       && !redirect_valid && !pred_redirect;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            pred_target   <= RESET_PC;
            outstanding   <= '0;
            drop_cnt      <= '0;
            pred_redirect <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);

            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale, including a same-cycle grant.
                fetch_pc      <= redirect_pc;
                resp_pc       <= redirect_pc;
                drop_cnt      <= outstanding_nxt;
                pred_redirect <= 1'b0;
            end else if (pred_redirect) begin
                fetch_pc      <= pred_target;
                resp_pc       <= pred_target;
                pred_redirect <= 1'b0;
            end else begin
                if (imem_gnt) fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                    if (pred_hit) begin
                        pred_redirect <= 1'b1;
                        pred_target   <= resp_pc + imm_b(imem_rdata);
                        drop_cnt      <= outstanding_nxt;
                    end
                end
            end
        end
    end

    assign pop = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign out_valid       = (fifo_count != '0);
    assign pc_out          = head.pc;
    assign pc_p4_out       = head.pc_p4;
    assign instr_out       = out_valid ? head.instr : NOP;
    assign branch_take_out = out_valid && head.pred;
    assign flush_out       = redirect_valid && !rst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with hold/force controls,
// pop capture log checked against a table of expected deliveries per scenario.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] pc_out, pc_p4_out, instr_out;
    logic        branch_take_out, flush_out;

    always #5 clk = ~clk;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc_out          (pc_out),
        .pc_p4_out       (pc_p4_out),
        .instr_out       (instr_out),
        .branch_take_out (branch_take_out),
        .flush_out       (flush_out)
    );

    int tests = 0;
    int fails = 0;

    // Memory model controls
    logic gnt_en, force_gnt, hold, br_en;
    logic [31:0] pend [16];
    logic [3:0]  wr_p, rd_p;

    // Logs
    logic [31:0] gnt_log [64];
    logic [31:0] cap_pc [64], cap_p4 [64], cap_in [64];
    logic        cap_tk [64];
    logic [6:0]  gnt_n, cap_n;
    int          cyc, first_gnt, first_vld;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (br_en && a == 32'h10) return 32'hFE00_0CE3;   // beq x0,x0,-8
        return 32'h0000_0013 | {a[11:0], 20'h0};
    endfunction

    assign imem_gnt    = (imem_req && gnt_en) || force_gnt;
    assign imem_rvalid = (wr_p != rd_p) && !hold;
    assign imem_rdata  = mem_word(pend[rd_p]);

    always @(posedge clk) begin
        if (rst) begin
            wr_p <= '0; rd_p <= '0; gnt_n <= '0; cap_n <= '0;
            cyc <= 0; first_gnt <= -1; first_vld <= -1;
        end else begin
            cyc <= cyc + 1;
            if (imem_gnt) begin
                pend[wr_p] <= imem_addr;
                wr_p <= wr_p + 4'd1;
                if (gnt_n < 7'd64) begin
                    gnt_log[gnt_n[5:0]] <= imem_addr;
                    gnt_n <= gnt_n + 7'd1;
                end
                if (first_gnt < 0) first_gnt <= cyc;
            end
            if (imem_rvalid) rd_p <= rd_p + 4'd1;
            if (out_valid && first_vld < 0) first_vld <= cyc;
            if (out_valid && out_ready && cap_n < 7'd64) begin
                cap_pc[cap_n[5:0]] <= pc_out;
                cap_p4[cap_n[5:0]] <= pc_p4_out;
                cap_in[cap_n[5:0]] <= instr_out;
                cap_tk[cap_n[5:0]] <= branch_take_out;
                cap_n <= cap_n + 7'd1;
            end
        end
    end

    typedef struct {
        int          scen;
        int          idx;
        logic [31:0] pc;
        logic        take;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input int s, input int i, input logic [31:0] pc, input logic t);
        vec_t v;
        v.scen = s; v.idx = i; v.pc = pc; v.take = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        force_gnt = 1'b0; gnt_en = 1'b1; hold = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_scen(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s) begin
                logic [5:0] k;
                logic       seen;
                k = 6'(vecs[i].idx);
                seen = (cap_n > {1'b0, k});
                chk($sformatf("s%0d.seen[%0d]", s, k), 32'(seen), 32'd1);
                if (seen) begin
                    chk($sformatf("s%0d.pc[%0d]", s, k),    cap_pc[k], vecs[i].pc);
                    chk($sformatf("s%0d.pc_p4[%0d]", s, k), cap_p4[k], vecs[i].pc + 32'd4);
                    chk($sformatf("s%0d.instr[%0d]", s, k), cap_in[k], mem_word(vecs[i].pc));
                    chk($sformatf("s%0d.take[%0d]", s, k),  32'(cap_tk[k]), 32'(vecs[i].take));
                end
            end
        end
    endtask

    initial begin
        logic found;

        for (int i = 0; i < 6; i++) addv(1, i, 32'(i * 4), 1'b0);
        for (int i = 0; i < 4; i++) addv(2, i, 32'(i * 4), 1'b0);
        addv(3, 0, 32'h00, 1'b0); addv(3, 1, 32'h04, 1'b0); addv(3, 2, 32'h08, 1'b0);
        addv(3, 3, 32'h0C, 1'b0); addv(3, 4, 32'h10, 1'b1); addv(3, 5, 32'h08, 1'b0);
        addv(3, 6, 32'h0C, 1'b0); addv(3, 7, 32'h10, 1'b1);
        addv(4, 0, 32'h100, 1'b0); addv(4, 1, 32'h104, 1'b0); addv(4, 2, 32'h108, 1'b0);
        addv(5, 0, 32'h200, 1'b0); addv(5, 1, 32'h204, 1'b0);
        addv(6, 0, 32'h00, 1'b0);  addv(6, 1, 32'h04, 1'b0);

        // 1: reset values (flush gated by reset), then steady streaming
        br_en = 1'b0; out_ready = 1'b1; gnt_en = 1'b1; force_gnt = 1'b0; hold = 1'b0;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(2);
        @(negedge clk);
        chk("rst.req",   32'(imem_req), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.instr", instr_out, 32'h0000_0013);
        chk("rst.take",  32'(branch_take_out), 32'd0);
        chk("rst.flush", 32'(flush_out), 32'd0);
        tick(1);
        rst = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("s1.addr0", imem_addr, 32'h0);
        chk("s1.req0",  32'(imem_req), 32'd1);
        tick(30);
        chk("s1.gnt0", gnt_log[0], 32'h0);
        chk("s1.gnt1", gnt_log[1], 32'h4);
        chk("s1.gnt2", gnt_log[2], 32'h8);
        chk("s1.lat",  32'(first_vld - first_gnt), 32'd2);
        check_scen(1);

        // 2: back-pressure fills the buffer, nothing lost on release
        out_ready = 1'b0;
        do_reset();
        tick(6);
        @(negedge clk);
        chk("s2.gnt_n", 32'(gnt_n), 32'd2);
        chk("s2.valid", 32'(out_valid), 32'd1);
        chk("s2.head",  pc_out, 32'h0);
        chk("s2.req",   32'(imem_req), 32'd0);
        tick(1);
        out_ready = 1'b1;
        tick(12);
        check_scen(2);

        // 3: backward branch at 0x10 predicted taken, 0x14 response dropped
        br_en = 1'b1; out_ready = 1'b1;
        do_reset();
        tick(40);
        found = 1'b0;
        for (int i = 0; i < 64; i++)
            if (7'(i) < gnt_n && gnt_log[6'(i)] == 32'h14) found = 1'b1;
        chk("s3.gnt14", 32'(found), 32'd1);
        check_scen(3);
        br_en = 1'b0;

        // 4: redirect with two requests outstanding
        out_ready = 1'b1;
        do_reset();
        hold = 1'b1;
        tick(4);
        @(negedge clk);
        chk("s4.gnt_n", 32'(gnt_n), 32'd2);
        chk("s4.req",   32'(imem_req), 32'd0);
        tick(1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("s4.flush", 32'(flush_out), 32'd1);
        chk("s4.req_r", 32'(imem_req), 32'd0);
        tick(1);
        redirect_valid = 1'b0; hold = 1'b0;
        @(negedge clk);
        chk("s4.empty", 32'(out_valid), 32'd0);
        chk("s4.flush0", 32'(flush_out), 32'd0);
        tick(15);
        check_scen(4);

        // 5: redirect coinciding with rvalid and gnt, non-empty buffer cleared
        out_ready = 1'b0;
        do_reset();
        tick(2);
        hold = 1'b1; gnt_en = 1'b0;
        tick(2);
        @(negedge clk);
        chk("s5.valid", 32'(out_valid), 32'd1);
        chk("s5.head",  pc_out, 32'h0);
        tick(1);
        hold = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; force_gnt = 1'b1;
        @(negedge clk);
        chk("s5.flush", 32'(flush_out), 32'd1);
        tick(1);
        redirect_valid = 1'b0; force_gnt = 1'b0; gnt_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("s5.empty", 32'(out_valid), 32'd0);
        tick(15);
        check_scen(5);

        // 6: reset with a full buffer, fetch restarts at RESET_PC
        out_ready = 1'b0;
        do_reset();
        tick(6);
        @(negedge clk);
        chk("s6.full", 32'(out_valid), 32'd1);
        tick(1);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("s6.valid", 32'(out_valid), 32'd0);
        chk("s6.req",   32'(imem_req), 32'd0);
        chk("s6.instr", instr_out, 32'h0000_0013);
        chk("s6.take",  32'(branch_take_out), 32'd0);
        tick(1);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("s6.addr", imem_addr, 32'h0);
        chk("s6.req1", 32'(imem_req), 32'd1);
        tick(12);
        check_scen(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
